// File: rtl/pin_arb_pkg.sv
// Shared types, limits and helpers for the round-robin pin-combine arbiter.
package pin_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DONE  = 2'd2
    } arb_state_e;

    localparam int NUM_REQ_MIN = 2;
    localparam int NUM_REQ_MAX = 16;
    localparam int HOLD_MIN    = 1;
    localparam int HOLD_MAX    = 15;
    localparam int HOLD_W      = 4;

    // Index width that never collapses to zero bits for tiny requester counts.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pin_rr_arbiter_rr_select.sv
// Combinational round-robin pick: first set request at or after rr_ptr,
// with one optional index masked out.
module rr_select
    import pin_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = clog2_min1(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    rr_ptr,
    input  logic [ID_W-1:0]    mask_idx,
    input  logic               mask_en,
    output logic               any_req,
    output logic [ID_W-1:0]    winner
);

    logic [NUM_REQ-1:0] masked;
    int                 idx;

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        masked = req;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (mask_en && (ID_W'(i) == mask_idx)) begin
                masked[i] = 1'b0;
            end
        end
        any_req = |masked;

        // Scan offsets from far to near so the nearest set bit is written last.
        winner = '0;
        idx    = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (masked[idx]) begin
                winner = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/pin_rr_arbiter.sv
// Round-robin sequencer sharing one registered pin_a | pin_b combine stage;
// granted operands are held HOLD_CYCLES cycles so the combine is multicycle.
module pin_rr_arbiter
    import pin_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = 8,
    parameter int HOLD_CYCLES = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*DATA_W-1:0]  pin_a,
    input  logic [NUM_REQ*DATA_W-1:0]  pin_b,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [NUM_REQ-1:0]         ack,
    output logic                       out_valid,
    output logic [DATA_W-1:0]          out_data,
    output logic [$clog2(NUM_REQ)-1:0] out_id,
    output logic                       busy
);

    localparam int                ID_W      = clog2_min1(NUM_REQ);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    if (NUM_REQ < NUM_REQ_MIN || NUM_REQ > NUM_REQ_MAX ||
        HOLD_CYCLES < HOLD_MIN || HOLD_CYCLES > HOLD_MAX) begin : g_param_check
        $error("pin_rr_arbiter: NUM_REQ or HOLD_CYCLES out of range");
    end

    arb_state_e          state_q, state_n;
    logic [ID_W-1:0]     winner_q, winner_n;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_n;
    logic [HOLD_W-1:0]   hold_q, hold_n;
    logic [NUM_REQ-1:0]  gnt_q, gnt_n;
    logic [NUM_REQ-1:0]  ack_q, ack_n;
    logic                out_valid_q, out_valid_n;
    logic [DATA_W-1:0]   out_data_q, out_data_n;
    logic [ID_W-1:0]     out_id_q, out_id_n;

    logic [ID_W-1:0]     ptr_inc;
    logic [ID_W-1:0]     sel_ptr;
    logic                sel_any;
    logic [ID_W-1:0]     sel_winner;

    // Explicit wrap: NUM_REQ need not be a power of two.
    assign ptr_inc = (winner_q == ID_W'(NUM_REQ - 1)) ? '0 : winner_q + 1'b1;
    // In DONE the pointer is already advancing, so arbitrate from its new value.
    assign sel_ptr = (state_q == DONE) ? ptr_inc : rr_ptr_q;

    rr_select #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_select (
        .req      (req),
        .rr_ptr   (sel_ptr),
        .mask_idx (winner_q),
        .mask_en  (state_q == DONE),
        .any_req  (sel_any),
        .winner   (sel_winner)
    );

    always_comb begin
        state_n     = state_q;
        winner_n    = winner_q;
        rr_ptr_n    = rr_ptr_q;
        hold_n      = '0;
        gnt_n       = '0;
        ack_n       = '0;
        out_valid_n = 1'b0;
        out_data_n  = out_data_q;
        out_id_n    = out_id_q;

        unique case (state_q)
            IDLE: begin
                if (sel_any) begin
                    state_n           = GRANT;
                    winner_n          = sel_winner;
                    gnt_n[sel_winner] = 1'b1;
                end
            end
            GRANT: begin
                if (!req[winner_q]) begin
                    state_n = IDLE;
                end else if (hold_q == HOLD_LAST) begin
                    state_n         = DONE;
                    ack_n[winner_q] = 1'b1;
                    out_valid_n     = 1'b1;
                    out_data_n      = pin_a[winner_q*DATA_W +: DATA_W]
                                    | pin_b[winner_q*DATA_W +: DATA_W];
                    out_id_n        = winner_q;
                end else begin
                    hold_n          = hold_q + 1'b1;
                    gnt_n[winner_q] = 1'b1;
                end
            end
            DONE: begin
                rr_ptr_n = ptr_inc;
                if (sel_any) begin
                    state_n           = GRANT;
                    winner_n          = sel_winner;
                    gnt_n[sel_winner] = 1'b1;
                end else begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            winner_q    <= '0;
            rr_ptr_q    <= '0;
            hold_q      <= '0;
            gnt_q       <= '0;
            ack_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= '0;
        end else begin
            state_q     <= state_n;
            winner_q    <= winner_n;
            rr_ptr_q    <= rr_ptr_n;
            hold_q      <= hold_n;
            gnt_q       <= gnt_n;
            ack_q       <= ack_n;
            out_valid_q <= out_valid_n;
            out_data_q  <= out_data_n;
            out_id_q    <= out_id_n;
        end
    end

    assign gnt       = gnt_q;
    assign ack       = ack_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_id    = out_id_q;
    assign busy      = (state_q != IDLE);

endmodule
